ps2_keyboard_rx: RTL and testbench

PS/2 keyboard receiver for the keyboard input path of the NPC top level. Oversamples the asynchronous PS/2 clock/data lines on the system clock and deserialises 11-bit device-to-host frames. Validated scan-code bytes go into a small FIFO, which the consumer drains with an active-low "next data" strobe. The block reports data availability (`ready`) and dropped bytes (`overflow`).

---
 rtl/ps2_keyboard_rx.sv | 109 ++++++++++
 tb/tb_ps2_keyboard_rx.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/ps2_keyboard_rx.sv
`timescale 1ns/1ps
// ps2_keyboard_rx
// Receives device-to-host PS/2 keyboard frames by oversampling the PS/2
// clock and data lines on the system clock. Good scan-code bytes are queued
// in a small FIFO, and the consumer drains that FIFO with an active-low
// "next data" strobe.
//
// Compile-time option:
//   PS2_PARITY_CHECK_EN - when defined, frames that fail odd parity are
//                         dropped. When undefined, the parity bit is
//                         ignored.
//
// Parameters:
//   FIFO_AW     FIFO address width. Depth is 2^FIFO_AW and usable
//               capacity is 2^FIFO_AW - 1 bytes.
//
// Ports:
//   clk         system clock, at least 10x the PS/2 clock rate
//   rst         asynchronous reset, active-high
//   ps2_clk     PS/2 clock line (asynchronous, idle high)
//   ps2_data    PS/2 data line (asynchronous, idle high)
//   nextdata_n  active-low pop request, sampled on the rising edge of clk
//   data        byte at the FIFO head, valid while ready = 1
//   ready       FIFO is not empty
//   overflow    sticky: a good frame was dropped because the FIFO was full
module ps2_keyboard_rx #(
   parameter int FIFO_AW = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   input  logic       nextdata_n,
   output logic [7:0] data,
   output logic       ready,
   output logic       overflow
);

`ifdef PS2_PARITY_CHECK_EN
   localparam bit PARITY_EN = 1'b1;
`else
   localparam bit PARITY_EN = 1'b0;
`endif

   localparam int DEPTH = 1 << FIFO_AW;

   logic [2:0]         clk_sync;
   logic               fe;
   logic [3:0]         cnt;
   logic [9:0]         buffer;
   logic [7:0]         fifo [0:DEPTH-1];
   logic [FIFO_AW-1:0] w_ptr;
   logic [FIFO_AW-1:0] r_ptr;
   logic [FIFO_AW-1:0] w_ptr_inc;
   logic [FIFO_AW-1:0] r_ptr_inc;
   logic               frame_done;
   logic               frame_ok;
   logic               full;
   logic               push;
   logic               pop;

   // A falling edge is seen across the two oldest synchroniser stages. This
   // keeps the newest stage out of the decision, so it can resolve any
   // metastability first.
   assign fe         = clk_sync[2] & ~clk_sync[1];
   assign frame_done = fe && (cnt == 4'd10);

   // On the stop-bit edge, ps2_data itself is the stop bit.
   // Parity is computed in every build and masked when the check is off, so
   // the parity bit is always read.
   assign frame_ok = ~buffer[0] & ps2_data & ((^buffer[9:1]) | ~PARITY_EN);

   assign w_ptr_inc = w_ptr + 1'b1;
   assign r_ptr_inc = r_ptr + 1'b1;
   assign ready     = (w_ptr != r_ptr);
   // The full test uses the pointers as they are before any pop this cycle.
   // A frame that arrives on a pop cycle into a full FIFO is still dropped.
   assign full      = (w_ptr_inc == r_ptr);
   assign push      = frame_done & frame_ok & ~full;
   assign pop       = ready & ~nextdata_n;
   assign data      = fifo[r_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clk_sync <= 3'b111;
         cnt      <= 4'd0;
         w_ptr    <= '0;
         r_ptr    <= '0;
         overflow <= 1'b0;
      end else begin
         clk_sync <= {clk_sync[1:0], ps2_clk};
         if (fe) begin
            if (cnt == 4'd10) cnt <= 4'd0;
            else              cnt <= cnt + 4'd1;
         end
         if (push) w_ptr <= w_ptr_inc;
         if (frame_done && frame_ok && full) overflow <= 1'b1;
         if (pop) r_ptr <= r_ptr_inc;
      end
   end

   // The frame buffer and the FIFO storage are not reset. Their contents are
   // only ever seen through cnt and the pointers, and those are reset.
   always_ff @(posedge clk) begin
      if (fe && (cnt < 4'd10)) buffer[cnt] <= ps2_data;
      if (push) fifo[w_ptr] <= buffer[8:1];
   end

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
`timescale 1ns/1ps
module tb_ps2_keyboard_rx;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic       nextdata_n = 1'b1;
   logic [7:0] data;
   logic       ready;
   logic       overflow;

   int checks = 0;
   int errors = 0;

   ps2_keyboard_rx #(.FIFO_AW(3)) dut (
      .clk        (clk),
      .rst        (rst),
      .ps2_clk    (ps2_clk),
      .ps2_data   (ps2_data),
      .nextdata_n (nextdata_n),
      .data       (data),
      .ready      (ready),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Frame layout: [0] start, [8:1] data LSB first, [9] parity, [10] stop.
   function automatic logic [10:0] mk(input logic [7:0] d, input logic par,
                                      input logic start, input logic stop);
      return {stop, par, d, start};
   endfunction

   function automatic logic [10:0] good(input logic [7:0] d);
      return mk(d, ~(^d), 1'b0, 1'b1);
   endfunction

   // Each PS/2 clock phase lasts 10 system clocks.
   task automatic send_bits(input logic [10:0] f, input int nbits);
      for (int i = 0; i < nbits; i++) begin
         ps2_data = f[i];
         #50;
         ps2_clk = 1'b0;
         #100;
         ps2_clk = 1'b1;
         #50;
      end
      ps2_data = 1'b1;
   endtask

   task automatic send_frame(input logic [10:0] f);
      send_bits(f, 11);
      #100;
   endtask

   task automatic pop_one;
      @(negedge clk);
      nextdata_n = 1'b0;
      @(negedge clk);
      nextdata_n = 1'b1;
   endtask

   initial begin
      #23;
      check("reset_ready", {7'd0, ready}, 8'h00);
      check("reset_overflow", {7'd0, overflow}, 8'h00);
      @(negedge clk);
      rst = 1'b0;
      #100;

      // Single frame
      send_frame(good(8'h1C));
      check("single_ready", {7'd0, ready}, 8'h01);
      check("single_data", data, 8'h1C);
      pop_one();
      check("single_pop_ready", {7'd0, ready}, 8'h00);
      check("single_overflow", {7'd0, overflow}, 8'h00);

      // FIFO order, drained with back-to-back pops
      send_frame(good(8'hF0));
      send_frame(good(8'h1C));
      check("order_first", data, 8'hF0);
      @(negedge clk);
      nextdata_n = 1'b0;
      @(negedge clk);
      check("order_second", data, 8'h1C);
      check("order_second_ready", {7'd0, ready}, 8'h01);
      @(negedge clk);
      nextdata_n = 1'b1;
      check("order_empty", {7'd0, ready}, 8'h00);

      // Bad parity
      send_frame(mk(8'h1C, 1'b1, 1'b0, 1'b1));
`ifdef PS2_PARITY_CHECK_EN
      check("badpar_ready", {7'd0, ready}, 8'h00);
`else
      check("badpar_ready", {7'd0, ready}, 8'h01);
      check("badpar_data", data, 8'h1C);
      pop_one();
`endif

      // Bad start, then bad stop, then a good frame
      send_frame(mk(8'h33, 1'b1, 1'b1, 1'b1));
      check("badstart_ready", {7'd0, ready}, 8'h00);
      send_frame(mk(8'h33, 1'b1, 1'b0, 1'b0));
      check("badstop_ready", {7'd0, ready}, 8'h00);
      send_frame(good(8'h29));
      check("after_bad_ready", {7'd0, ready}, 8'h01);
      check("after_bad_data", data, 8'h29);
      pop_one();

      // Overflow
      for (int i = 1; i <= 8; i++) send_frame(good(i[7:0]));
      check("ovf_flag", {7'd0, overflow}, 8'h01);
      for (int i = 1; i <= 7; i++) begin
         check($sformatf("ovf_drain_%0d", i), data, i[7:0]);
         pop_one();
      end
      check("ovf_empty", {7'd0, ready}, 8'h00);
      check("ovf_sticky", {7'd0, overflow}, 8'h01);

      // Reset in the middle of a frame, with one byte queued
      send_frame(good(8'h77));
      check("pre_rst_ready", {7'd0, ready}, 8'h01);
      send_bits(good(8'h44), 5);
      #33;
      rst = 1'b1;
      #1;
      check("midrst_ready", {7'd0, ready}, 8'h00);
      check("midrst_overflow", {7'd0, overflow}, 8'h00);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #100;
      send_frame(good(8'h5A));
      check("postrst_ready", {7'd0, ready}, 8'h01);
      check("postrst_data", data, 8'h5A);
      pop_one();
      check("postrst_empty", {7'd0, ready}, 8'h00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
